// File: rtl/sr_flip_flop_pkg.sv
// sr_pkg: policy codes for resolving S=R=1 and the per-bit resolver.
package sr_pkg;
  localparam int INV_HOLD = 0;
  localparam int INV_CLR  = 1;
  localparam int INV_SET  = 2;
  localparam int INV_TOG  = 3;
  // Unknown policy codes fall back to hold.
  function automatic logic resolve(int mode, logic q);
    return mode == INV_CLR ? 1'b0 : mode == INV_SET ? 1'b1 : mode == INV_TOG ? ~q : q;
  endfunction
endpackage

// File: rtl/sr_flip_flop_if.sv
// sr_flip_flop_if: request and status bundle of the SR flip-flop bank.
interface sr_flip_flop_if #(parameter int WIDTH = 1, parameter int CNT_W = 8);
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] R;
  logic             clr_cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             invalid;
  logic [CNT_W-1:0] invalid_cnt;
  modport master (output S, R, clr_cnt, input q, qn, invalid, invalid_cnt);
  modport slave  (input S, R, clr_cnt, output q, qn, invalid, invalid_cnt);
endinterface

// File: rtl/sr_flip_flop_cell.sv
// sr_cell: single-bit clocked SR register with async reset and S=R=1 policy.
module sr_cell
  import sr_pkg::*;
#(
  parameter int   INVALID_MODE = INV_HOLD,
  parameter logic RESET_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q
);
  logic d;
  always_comb d = s && r ? resolve(INVALID_MODE, q) : s ? 1'b1 : r ? 1'b0 : q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= RESET_VAL;
    else q <= d;
endmodule

// File: rtl/sr_flip_flop.sv
// sr_flip_flop: WIDTH independent SR cells plus invalid flag and saturating invalid counter.
module sr_flip_flop
  import sr_pkg::*;
#(
  parameter int               WIDTH        = 1,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0,
  parameter int               INVALID_MODE = INV_HOLD,
  parameter int               CNT_W        = 8
) (
  input logic           clk,
  input logic           rst,
  sr_flip_flop_if.slave bus
);
  logic [WIDTH-1:0] q_r;
  logic             any_inv;
  logic             inv_r;
  logic [CNT_W-1:0] cnt_r;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(.INVALID_MODE(INVALID_MODE), .RESET_VAL(RESET_VAL[i])) u_cell (
      .clk(clk),
      .rst(rst),
      .s  (bus.S[i]),
      .r  (bus.R[i]),
      .q  (q_r[i])
    );
  end
  assign any_inv = |(bus.S & bus.R);
  // Clear beats a simultaneous increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      inv_r <= 1'b0;
      cnt_r <= '0;
    end else begin
      inv_r <= any_inv;
      cnt_r <= bus.clr_cnt ? '0 : (any_inv && cnt_r != '1) ? cnt_r + 1'b1 : cnt_r;
    end
  assign bus.q           = q_r;
  assign bus.qn          = ~q_r;
  assign bus.invalid     = inv_r;
  assign bus.invalid_cnt = cnt_r;
endmodule

// File: tb/tb_sr_flip_flop.sv
// tb_sr_flip_flop: scoreboard bench over six configurations of the SR bank.
`timescale 1ps/1ps
module tb_sr_flip_flop;
  typedef struct packed {
    logic [5:0][3:0] q;
    logic [5:0]      inv;
    logic [5:0][7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] s = '0;
  logic [3:0] r = '0;
  logic       clr = 1'b0;
  logic [3:0] q_a [6];
  logic [3:0] qn_a [6];
  logic       inv_a [6];
  logic [7:0] cnt_a [6];
  logic [3:0] mq [6];
  int         mcnt [6];
  exp_t       sb [$];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  // Duts 0..4: WIDTH=4, CNT_W=2, policies 0,1,2,3 and illegal 7.
  for (genvar k = 0; k < 5; k++) begin : g_dut
    sr_flip_flop_if #(.WIDTH(4), .CNT_W(2)) bus ();
    assign bus.S       = s;
    assign bus.R       = r;
    assign bus.clr_cnt = clr;
    sr_flip_flop #(.WIDTH(4), .RESET_VAL(4'b0000), .INVALID_MODE(k == 4 ? 7 : k), .CNT_W(2)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    assign q_a[k]   = bus.q;
    assign qn_a[k]  = bus.qn;
    assign inv_a[k] = bus.invalid;
    assign cnt_a[k] = {6'b0, bus.invalid_cnt};
  end

  // Dut 5: scalar drop-in, toggle policy, 8-bit counter.
  sr_flip_flop_if #(.WIDTH(1), .CNT_W(8)) bus1 ();
  assign bus1.S       = s[0];
  assign bus1.R       = r[0];
  assign bus1.clr_cnt = clr;
  sr_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0), .INVALID_MODE(3), .CNT_W(8)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );
  assign q_a[5]   = {3'b000, bus1.q};
  assign qn_a[5]  = {3'b000, bus1.qn};
  assign inv_a[5] = bus1.invalid;
  assign cnt_a[5] = bus1.invalid_cnt;

  function automatic int mode_of(int d);
    return d == 4 ? 7 : d == 5 ? 3 : d;
  endfunction

  function automatic logic [3:0] mask_of(int d);
    return d == 5 ? 4'b0001 : 4'b1111;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", n, act, req);
    end
  endtask

  task automatic chk_reset(string tag);
    for (int d = 0; d < 6; d++) begin
      chk($sformatf("%s q dut%0d", tag, d), 32'(q_a[d]), 0);
      chk($sformatf("%s qn dut%0d", tag, d), 32'(qn_a[d]), 32'(mask_of(d)));
      chk($sformatf("%s invalid dut%0d", tag, d), 32'(inv_a[d]), 0);
      chk($sformatf("%s cnt dut%0d", tag, d), 32'(cnt_a[d]), 0);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 6; d++) begin
      mq[d]   = '0;
      mcnt[d] = 0;
    end
  endtask

  // Drive one edge's worth of requests and queue the expected post-edge state.
  task automatic step(logic [3:0] si, logic [3:0] ri, logic ci);
    exp_t e;
    @(negedge clk);
    s   = si;
    r   = ri;
    clr = ci;
    for (int d = 0; d < 6; d++) begin
      int  w  = d == 5 ? 1 : 4;
      int  mx = d == 5 ? 255 : 3;
      int  m  = mode_of(d);
      logic any = d == 5 ? (si[0] & ri[0]) : |(si & ri);
      for (int b = 0; b < w; b++) begin
        if (si[b] && ri[b]) mq[d][b] = m == 1 ? 1'b0 : m == 2 ? 1'b1 : m == 3 ? ~mq[d][b] : mq[d][b];
        else if (si[b]) mq[d][b] = 1'b1;
        else if (ri[b]) mq[d][b] = 1'b0;
      end
      if (ci) mcnt[d] = 0;
      else if (any && mcnt[d] < mx) mcnt[d] = mcnt[d] + 1;
      e.q[d]   = mq[d];
      e.inv[d] = any;
      e.cnt[d] = 8'(mcnt[d]);
    end
    sb.push_back(e);
  endtask

  // Monitor: after each edge, compare every dut against the oldest expectation.
  always begin
    @(posedge clk);
    #1;
    if (!rst && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      for (int d = 0; d < 6; d++) begin
        chk($sformatf("q dut%0d", d), 32'(q_a[d] & mask_of(d)), 32'(e.q[d]));
        chk($sformatf("qn dut%0d", d), 32'(qn_a[d] & mask_of(d)), 32'(~e.q[d] & mask_of(d)));
        chk($sformatf("invalid dut%0d", d), 32'(inv_a[d]), 32'(e.inv[d]));
        chk($sformatf("cnt dut%0d", d), 32'(cnt_a[d]), 32'(e.cnt[d]));
      end
    end
  end

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #1 chk_reset("async_reset");
    repeat (2) @(posedge clk);
    #1 chk_reset("reset_held");
    @(negedge clk);
    rst = 1'b0;
    step(4'h0, 4'h0, 1'b0);
    step(4'hF, 4'h0, 1'b0);
    step(4'h0, 4'h0, 1'b0);
    step(4'h0, 4'hF, 1'b0);
    step(4'hF, 4'h0, 1'b0);
    step(4'hF, 4'hF, 1'b0);
    step(4'h0, 4'h0, 1'b0);
    step(4'h0, 4'hF, 1'b0);
    repeat (4) step(4'hF, 4'hF, 1'b0);
    step(4'hF, 4'hF, 1'b1);
    step(4'h0, 4'h0, 1'b0);
    step(4'b1010, 4'b0101, 1'b0);
    step(4'b0011, 4'b0101, 1'b0);
    repeat (150) step(4'($urandom), 4'($urandom), 1'($urandom_range(0, 7) == 0));
    step(4'hF, 4'h0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset("mid_reset");
    @(posedge clk);
    #1 chk_reset("mid_reset_edge");
    @(negedge clk);
    s   = '0;
    r   = '0;
    clr = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (60) step(4'($urandom), 4'($urandom), 1'($urandom_range(0, 15) == 0));
    repeat (3) @(posedge clk);
    #2 chk("scoreboard_drain", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
